// File: rtl/pipe_hazard_regs.sv
// pipe_hazard_regs: PC register, IF/ID and ID/EX pipeline registers,
// ID branch-compare forwarding and EX operand forwarding for the 5-stage
// MIPS pipeline. Obeys the hazard unit's stall/flush/forward selects and
// keeps saturating stall/flush/redirect event counters for debug readout.
module pipe_hazard_regs #(
    parameter int              DW       = 32,
    parameter int              CW       = 12,
    parameter logic [DW-1:0]   RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             StallF,
    input  logic             StallD,
    input  logic             FlushE,
    input  logic             ForwardAD,
    input  logic             ForwardBD,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic             BranchD,
    input  logic             JumpD,
    input  logic [DW-1:0]    PCBranchD,
    input  logic [DW-1:0]    PCJumpD,
    input  logic [DW-1:0]    InstrF,
    input  logic [DW-1:0]    PCPlus4F,
    input  logic [DW-1:0]    RD1D,
    input  logic [DW-1:0]    RD2D,
    input  logic [CW-1:0]    CtrlD,
    input  logic [4:0]       RsD,
    input  logic [4:0]       RtD,
    input  logic [4:0]       RdD,
    input  logic [DW-1:0]    ALUOutM,
    input  logic [DW-1:0]    ResultW,
    output logic [DW-1:0]    PCF,
    output logic [DW-1:0]    InstrD,
    output logic [DW-1:0]    PCPlus4D,
    output logic             PCSrcD,
    output logic [CW-1:0]    CtrlE,
    output logic [4:0]       RsE,
    output logic [4:0]       RtE,
    output logic [4:0]       RdE,
    output logic [DW-1:0]    SrcAE,
    output logic [DW-1:0]    WriteDataE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic [CNT_W-1:0] RedirCnt
);

    logic [DW-1:0] cmpA;
    logic [DW-1:0] cmpB;
    logic [DW-1:0] RD1E;
    logic [DW-1:0] RD2E;
    logic          redirect;

    // ID-stage branch compare with forwarding from MEM
    assign cmpA     = ForwardAD ? ALUOutM : RD1D;
    assign cmpB     = ForwardBD ? ALUOutM : RD2D;
    assign PCSrcD   = BranchD & (cmpA == cmpB);
    assign redirect = JumpD | PCSrcD;

    // PC register: stall holds, jump beats branch, else sequential fetch
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            PCF <= RESET_PC;
        end else if (!StallF) begin
            if (JumpD)       PCF <= PCJumpD;
            else if (PCSrcD) PCF <= PCBranchD;
            else             PCF <= PCPlus4F;
        end
    end

    // IF/ID register: stall holds (wins over squash), redirect squashes to NOP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            InstrD   <= '0;
            PCPlus4D <= '0;
        end else if (!StallD) begin
            if (redirect) begin
                InstrD   <= '0;
                PCPlus4D <= '0;
            end else begin
                InstrD   <= InstrF;
                PCPlus4D <= PCPlus4F;
            end
        end
    end

    // ID/EX register: always advances, flush inserts a bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || FlushE) begin
            CtrlE <= '0;
            RsE   <= '0;
            RtE   <= '0;
            RdE   <= '0;
            RD1E  <= '0;
            RD2E  <= '0;
        end else begin
            CtrlE <= CtrlD;
            RsE   <= RsD;
            RtE   <= RtD;
            RdE   <= RdD;
            RD1E  <= RD1D;
            RD2E  <= RD2D;
        end
    end

    // EX operand forwarding muxes; reserved select 11 behaves as 00
    always_comb begin
        // NOTE: defaults first so no path leaves an output unassigned (no latch).
        SrcAE      = RD1E;
        WriteDataE = RD2E;
        case (ForwardAE)
            2'b01:   SrcAE = ResultW;
            2'b10:   SrcAE = ALUOutM;
            default: SrcAE = RD1E;
        endcase
        case (ForwardBE)
            2'b01:   WriteDataE = ResultW;
            2'b10:   WriteDataE = ALUOutM;
            default: WriteDataE = RD2E;
        endcase
    end

    // Saturating event counters; each stops at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            StallCnt <= '0;
            FlushCnt <= '0;
            RedirCnt <= '0;
        end else begin
            if (StallF && (StallCnt != '1))
                StallCnt <= StallCnt + CNT_W'(1);
            if (FlushE && (FlushCnt != '1))
                FlushCnt <= FlushCnt + CNT_W'(1);
            if (redirect && !StallD && (RedirCnt != '1))
                RedirCnt <= RedirCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_hazard_regs.sv
// Directed bench for pipe_hazard_regs: reset, load-use stall, forwarded
// branch, EX forwarding sweep, jump+branch under stall, counter saturation
// and asynchronous mid-stream reset. DUT built with 4-bit counters.
module tb_pipe_hazard_regs;

    localparam int DW    = 32;
    localparam int CW    = 12;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst_n;
    logic             StallF, StallD, FlushE;
    logic             ForwardAD, ForwardBD;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             BranchD, JumpD;
    logic [DW-1:0]    PCBranchD, PCJumpD, InstrF, PCPlus4F, RD1D, RD2D;
    logic [CW-1:0]    CtrlD;
    logic [4:0]       RsD, RtD, RdD;
    logic [DW-1:0]    ALUOutM, ResultW;
    logic [DW-1:0]    PCF, InstrD, PCPlus4D;
    logic             PCSrcD;
    logic [CW-1:0]    CtrlE;
    logic [4:0]       RsE, RtE, RdE;
    logic [DW-1:0]    SrcAE, WriteDataE;
    logic [CNT_W-1:0] StallCnt, FlushCnt, RedirCnt;

    int nChecks = 0;
    int nFails  = 0;

    typedef struct {
        logic        fad;
        logic        fbd;
        logic        br;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] alu;
        logic        expSrc;
    } cmpVec_t;

    typedef struct {
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic [31:0] expA;
        logic [31:0] expB;
    } exVec_t;

    cmpVec_t cmpVecs[6];
    exVec_t  exVecs[4];

    pipe_hazard_regs #(
        .DW(DW), .CW(CW), .RESET_PC(32'h0000_0000), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .StallF(StallF), .StallD(StallD), .FlushE(FlushE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .BranchD(BranchD), .JumpD(JumpD),
        .PCBranchD(PCBranchD), .PCJumpD(PCJumpD),
        .InstrF(InstrF), .PCPlus4F(PCPlus4F),
        .RD1D(RD1D), .RD2D(RD2D), .CtrlD(CtrlD),
        .RsD(RsD), .RtD(RtD), .RdD(RdD),
        .ALUOutM(ALUOutM), .ResultW(ResultW),
        .PCF(PCF), .InstrD(InstrD), .PCPlus4D(PCPlus4D), .PCSrcD(PCSrcD),
        .CtrlE(CtrlE), .RsE(RsE), .RtE(RtE), .RdE(RdE),
        .SrcAE(SrcAE), .WriteDataE(WriteDataE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt), .RedirCnt(RedirCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one rising edge and settle just after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        cmpVecs[0] = '{1'b0, 1'b0, 1'b1, 32'd5, 32'd5, 32'd9, 1'b1};
        cmpVecs[1] = '{1'b0, 1'b0, 1'b0, 32'd5, 32'd5, 32'd9, 1'b0};
        cmpVecs[2] = '{1'b1, 1'b0, 1'b1, 32'd5, 32'd9, 32'd9, 1'b1};
        cmpVecs[3] = '{1'b0, 1'b1, 1'b1, 32'd9, 32'd5, 32'd9, 1'b1};
        cmpVecs[4] = '{1'b1, 1'b1, 1'b1, 32'd1, 32'd2, 32'd9, 1'b1};
        cmpVecs[5] = '{1'b0, 1'b1, 1'b1, 32'd5, 32'd9, 32'd6, 1'b0};

        exVecs[0] = '{2'b00, 2'b00, 32'h1, 32'h2};
        exVecs[1] = '{2'b01, 2'b01, 32'hB, 32'hB};
        exVecs[2] = '{2'b10, 2'b10, 32'hA, 32'hA};
        exVecs[3] = '{2'b11, 2'b11, 32'h1, 32'h2};

        // Reset with quiet controls
        rst_n = 1'b0;
        StallF = 0; StallD = 0; FlushE = 0;
        ForwardAD = 0; ForwardBD = 0; ForwardAE = 2'b00; ForwardBE = 2'b00;
        BranchD = 0; JumpD = 0;
        PCBranchD = '0; PCJumpD = '0;
        InstrF = 32'h8C01_0004; PCPlus4F = 32'h4;
        RD1D = '0; RD2D = '0; CtrlD = '0; RsD = '0; RtD = '0; RdD = '0;
        ALUOutM = '0; ResultW = '0;
        #12;
        check("reset PCF", PCF, 32'h0);
        check("reset InstrD", InstrD, 32'h0);
        check("reset CtrlE", CtrlE, 32'h0);
        check("reset StallCnt", StallCnt, 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("first PCF", PCF, 32'h4);
        check("first InstrD", InstrD, 32'h8C01_0004);
        check("first PCPlus4D", PCPlus4D, 32'h4);
        check("first StallCnt", StallCnt, 32'h0);
        check("first FlushCnt", FlushCnt, 32'h0);
        check("first RedirCnt", RedirCnt, 32'h0);

        // Normal advance loading ID/EX
        CtrlD = 12'hABC; RsD = 5'd3; RtD = 5'd4; RdD = 5'd5;
        InstrF = 32'h1111_1111; PCPlus4F = 32'h8;
        tick();
        check("adv PCF", PCF, 32'h8);
        check("adv InstrD", InstrD, 32'h1111_1111);
        check("adv CtrlE", CtrlE, 32'hABC);
        check("adv RsE", RsE, 32'd3);
        check("adv RdE", RdE, 32'd5);

        // Load-use: stall front end, bubble into EX
        StallF = 1; StallD = 1; FlushE = 1;
        InstrF = 32'h2222_2222; PCPlus4F = 32'hC;
        tick();
        check("lu PCF hold", PCF, 32'h8);
        check("lu InstrD hold", InstrD, 32'h1111_1111);
        check("lu CtrlE bubble", CtrlE, 32'h0);
        check("lu RtE bubble", RtE, 32'h0);
        check("lu StallCnt", StallCnt, 32'h1);
        check("lu FlushCnt", FlushCnt, 32'h1);
        StallF = 0; StallD = 0; FlushE = 0;
        tick();
        check("lu resume PCF", PCF, 32'hC);
        check("lu resume InstrD", InstrD, 32'h2222_2222);
        check("lu resume CtrlE", CtrlE, 32'hABC);
        check("lu resume StallCnt", StallCnt, 32'h1);
        check("lu resume FlushCnt", FlushCnt, 32'h1);

        // ID compare table, all applied between two edges
        for (int i = 0; i < 6; i++) begin
            ForwardAD = cmpVecs[i].fad;
            ForwardBD = cmpVecs[i].fbd;
            BranchD   = cmpVecs[i].br;
            RD1D      = cmpVecs[i].rd1;
            RD2D      = cmpVecs[i].rd2;
            ALUOutM   = cmpVecs[i].alu;
            #1;
            check($sformatf("cmp[%0d] PCSrcD", i), PCSrcD, cmpVecs[i].expSrc);
        end

        // Taken branch with forwarded operand A
        BranchD = 1; ForwardAD = 1; ForwardBD = 0;
        ALUOutM = 32'd7; RD1D = 32'd3; RD2D = 32'd7; PCBranchD = 32'h40;
        #1;
        check("br PCSrcD", PCSrcD, 32'h1);
        tick();
        check("br PCF", PCF, 32'h40);
        check("br InstrD squash", InstrD, 32'h0);
        check("br PCPlus4D squash", PCPlus4D, 32'h0);
        check("br RedirCnt", RedirCnt, 32'h1);
        BranchD = 0; ForwardAD = 0;

        // EX forwarding sweep on RD1E=1, RD2E=2
        RD1D = 32'h1; RD2D = 32'h2;
        InstrF = 32'h3333_3333; PCPlus4F = 32'h44;
        tick();
        check("ex PCF", PCF, 32'h44);
        check("ex InstrD", InstrD, 32'h3333_3333);
        ALUOutM = 32'hA; ResultW = 32'hB;
        for (int i = 0; i < 4; i++) begin
            ForwardAE = exVecs[i].fa;
            ForwardBE = exVecs[i].fb;
            #1;
            check($sformatf("ex[%0d] SrcAE", i), SrcAE, exVecs[i].expA);
            check($sformatf("ex[%0d] WriteDataE", i), WriteDataE, exVecs[i].expB);
        end
        ForwardAE = 2'b00; ForwardBE = 2'b00;

        // Jump and taken branch together, first under stall
        @(negedge clk);
        JumpD = 1; BranchD = 1; ForwardAD = 0; ForwardBD = 0;
        RD1D = 32'd5; RD2D = 32'd5; PCJumpD = 32'h100; PCBranchD = 32'h40;
        StallF = 1; StallD = 1;
        tick();
        check("jb stall PCF", PCF, 32'h44);
        check("jb stall InstrD", InstrD, 32'h3333_3333);
        check("jb stall RedirCnt", RedirCnt, 32'h1);
        check("jb stall StallCnt", StallCnt, 32'h2);
        StallF = 0; StallD = 0;
        tick();
        check("jb PCF jump wins", PCF, 32'h100);
        check("jb InstrD squash", InstrD, 32'h0);
        check("jb RedirCnt", RedirCnt, 32'h2);
        JumpD = 0; BranchD = 0;

        // Saturation: 20 stalled cycles from StallCnt=2
        StallF = 1; StallD = 1;
        repeat (20) @(posedge clk);
        #1;
        check("sat StallCnt", StallCnt, 32'hF);
        check("sat PCF hold", PCF, 32'h100);
        check("sat RedirCnt", RedirCnt, 32'h2);

        // Asynchronous reset mid-cycle
        #3;
        rst_n = 1'b0;
        #1;
        check("areset StallCnt", StallCnt, 32'h0);
        check("areset FlushCnt", FlushCnt, 32'h0);
        check("areset RedirCnt", RedirCnt, 32'h0);
        check("areset PCF", PCF, 32'h0);
        check("areset InstrD", InstrD, 32'h0);

        @(negedge clk);
        StallF = 0; StallD = 0;
        InstrF = 32'h8C01_0004; PCPlus4F = 32'h4;
        rst_n = 1'b1;
        tick();
        check("rerun PCF", PCF, 32'h4);
        check("rerun InstrD", InstrD, 32'h8C01_0004);
        check("rerun StallCnt", StallCnt, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
